parity_frame_checker: RTL
=========================

# parity_frame_checker

Registered byte-stream parity checker for the schematic macro library: the stage directly downstream of the 8-input XOR parity macro. It consumes 8-bit data bytes, each with a received parity bit, and computes the 9-input parity of every byte. It flags per-byte parity errors, accumulates frame-level parity and error status across LAST-delimited frames, and passes the data through a one-deep registered valid/ready stage. Typical use is between a deserializer and the packet logic in a Lattice fabric design.

## Interface
- CNT_W, 8, width of the saturating error counter ECNT (1..16)
- CK  in  1  clock; all state updates on rising edge
- CD  in  1  reset, asynchronous, active-high; clears all state
- CLR  in  1  synchronous clear of ECNT only
- ODD  in  1  parity sense: 0 = even, 1 = odd; sampled with each accepted byte
- DI  in  8  input data byte
- PI  in  1  received parity bit for DI
- DV  in  1  input valid
- LI  in  1  input last-byte-of-frame marker
- DR  out  1  input ready
- DO  out  8  registered data byte
- PE  out  1  registered per-byte parity error, aligned with DO
- LO  out  1  registered last marker, aligned with DO
- OV  out  1  output valid
- ORDY  in  1  downstream ready
- FP  out  1  frame parity: XOR of all data bits of the most recently completed frame
- FE  out  1  frame error: OR of PE over the most recently completed frame
- FDONE  out  1  one-cycle pulse: a frame has completed
- ECNT  out  CNT_W  count of bytes with PE=1, saturating

## Operation
- Accept condition: DV & DR. DR = !OV | ORDY (combinational; one-deep pipeline register with pass-through ready).
- Per-byte check: PE = DI[0]^…^DI[7]^PI^ODD. Even parity is correct when the 9-bit XOR is 0; odd parity is correct when it is 1.
- On accept: DO/PE/LO load and OV sets. On OV & ORDY without an accept: OV clears. Accept and drain in the same cycle: registers reload and OV stays 1.
- Frame FSM, two states:
  - IDLE: no frame in progress. An accept with LI=0 goes to ACTIVE. An accept with LI=1 is a single-byte frame and stays IDLE.
  - ACTIVE: an accept with LI=0 stays ACTIVE. An accept with LI=1 goes to IDLE.
- Accumulators: running parity rp and running error re. The first byte of a frame (accepted in IDLE) loads rp = ^DI and re = PE. Subsequent bytes XOR into rp and OR into re.
- On the accept with LI=1: FP and FE load the final values including that byte, and FDONE pulses. FP and FE then hold until the next frame completes.
- ECNT: +1 on every accept with PE=1. Saturates at 2^CNT_W-1 without wrapping.
- CLR and an error accept in the same cycle: CLR wins, ECNT=0.
- CD mid-frame: the partial frame is discarded, the FSM returns to IDLE and no FDONE is produced.
- DV=0 cycles inside a frame are legal; accumulators hold.

## Timing
- Reset values: DO=0, PE=0, LO=0, OV=0, FP=0, FE=0, FDONE=0, ECNT=0, FSM=IDLE. DR=1 while CD is released.
- Latency: a byte accepted at edge N appears on DO/PE/LO with OV=1 after edge N, i.e. in cycle N+1.
- FDONE is high in cycle N+1 only, in the same cycle LO first presents, independent of ORDY. FP and FE are valid from cycle N+1.
- Throughput: one byte per clock while ORDY=1.
- While OV=1 and ORDY=0, DR=0 and DO/PE/LO hold stable.
- ODD is used only in the accept cycle. Changing ODD mid-frame affects only subsequent bytes.

## Configuration
- PARITY_ERRCNT_EN defined: ECNT and CLR are implemented as specified.
- PARITY_ERRCNT_EN undefined: the counter is removed, ECNT is tied to 0 and CLR is ignored. All other behaviour is unchanged.

## Test plan
- Reset/idle: assert CD mid-stream, then release. Required: all outputs at their reset values, DR=1, no FDONE.
- Even parity, ORDY=1, ODD=0: send DI=0x03/PI=0, then DI=0x07/PI=0, then DI=0x01/PI=1 with LI=1. Required: PE=0,1,0 in consecutive cycles; FDONE in the cycle after the third accept with FP=0 (2^3^1 set bits = 0), FE=1; ECNT=1.
- Odd parity: ODD=1, DI=0x00/PI=1 with LI=1. Required: PE=0, FP=0, FE=0, FDONE one cycle.
- Backpressure: hold ORDY=0 after the first byte. Required: DR=0 and DO held. Then set ORDY=1 with DV=1 the same cycle. Required: drain and accept occur together and OV stays 1.
- Saturation, CNT_W=2: send 5 error bytes. Required: ECNT=3. Then pulse CLR together with an error accept. Required: ECNT=0.
- Reset mid-frame: send 2 bytes with LI=0, pulse CD, then send one byte with LI=1. Required: FDONE once, with FP and FE computed from that byte only.

Source files
------------

// File: rtl/parity_frame_checker.sv
// Registered byte-stream parity checker with LAST-delimited frame parity/error accumulation.
// Optional saturating error counter: define PARITY_ERRCNT_EN to implement ECNT/CLR.
module parity_frame_checker #(
    parameter int CNT_W = 8
) (
    input  logic             CK,
    input  logic             CD,
    input  logic             CLR,
    input  logic             ODD,
    input  logic [7:0]       DI,
    input  logic             PI,
    input  logic             DV,
    input  logic             LI,
    output logic             DR,
    output logic [7:0]       DO,
    output logic             PE,
    output logic             LO,
    output logic             OV,
    input  logic             ORDY,
    output logic             FP,
    output logic             FE,
    output logic             FDONE,
    output logic [CNT_W-1:0] ECNT
);

    // Valid/ready: a byte moves when valid and ready are both high at a rising edge.
    // DR depends only on OV and ORDY, never on DV.
    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} frame_state_t;

    frame_state_t state_q, state_d;
    logic         accept;
    logic         data_par;
    logic         byte_pe;
    logic         rp_q, re_q;
    logic         rp_d, re_d;
    logic         frame_par, frame_err;

    assign DR       = !OV || ORDY;
    assign accept   = DV && DR;
    assign data_par = ^DI;
    assign byte_pe  = data_par ^ PI ^ ODD;

    // The first byte of a frame restarts the accumulators instead of folding in.
    assign frame_par = (state_q == IDLE) ? data_par : (rp_q ^ data_par);
    assign frame_err = (state_q == IDLE) ? byte_pe  : (re_q | byte_pe);

    always_comb begin
        state_d = state_q;
        rp_d    = rp_q;
        re_d    = re_q;
        if (accept) begin
            rp_d    = frame_par;
            re_d    = frame_err;
            state_d = LI ? IDLE : ACTIVE;
        end
    end

    always_ff @(posedge CK or posedge CD) begin
        if (CD) begin
            state_q <= IDLE;
            rp_q    <= 1'b0;
            re_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rp_q    <= rp_d;
            re_q    <= re_d;
        end
    end

    always_ff @(posedge CK or posedge CD) begin
        if (CD) begin
            DO <= 8'h00;
            PE <= 1'b0;
            LO <= 1'b0;
            OV <= 1'b0;
        end else if (accept) begin
            DO <= DI;
            PE <= byte_pe;
            LO <= LI;
            OV <= 1'b1;
        end else if (ORDY) begin
            OV <= 1'b0;
        end
    end

    // FP/FE hold between frames; FDONE fires with the first presentation of the last byte.
    always_ff @(posedge CK or posedge CD) begin
        if (CD) begin
            FP    <= 1'b0;
            FE    <= 1'b0;
            FDONE <= 1'b0;
        end else begin
            FDONE <= accept && LI;
            if (accept && LI) begin
                FP <= frame_par;
                FE <= frame_err;
            end
        end
    end

`ifdef PARITY_ERRCNT_EN
    logic [CNT_W-1:0] ecnt_q;

    always_ff @(posedge CK or posedge CD) begin
        if (CD) begin
            ecnt_q <= '0;
        end else if (CLR) begin
            ecnt_q <= '0;
        end else if (accept && byte_pe && (ecnt_q != {CNT_W{1'b1}})) begin
            ecnt_q <= ecnt_q + CNT_W'(1);
        end
    end

    assign ECNT = ecnt_q;
`else
    logic unused_clr;

    assign unused_clr = CLR;
    assign ECNT       = '0;
`endif

endmodule
